bus_slave_port: RTL
===================

Name: bus_slave_port

Overview:
Slave-side responder for the serial shared bus. It connects to one slave slot of the interconnect: one AD_SEL bit, B_BUS_OUTS/B_RWS inputs, and B_BUS_INS/B_READYS/B_ACKS/B_SBSY outputs.
- Deserialises the address and write data, commits writes into a local word memory, serialises read data back, and signals ACK.
- Optionally asserts busy (split) during a configurable read latency so the arbiter can release the bus.

Parameters:
ADDR_W, 12, serial address bits per transaction; local memory holds 2**ADDR_W words
DATA_W, 8, serial data bits per transaction
READ_LATENCY, 0, cycles of busy (B_SBSY) between address completion and read data availability; 0 disables split

Ports:
CLK  in  1  clock, all state on rising edge
RSTN  in  1  asynchronous active-low reset
SEL  in  1  this slave selected (its AD_SEL bit)
B_UTIL  in  1  bus in use by granted master
A_ADD  in  1  address phase qualifier; B_BUS_OUT carries an address bit
B_BUS_OUT  in  1  serial address/write-data bit from master
B_RW  in  1  1 = write, 0 = read (this slave's B_RWS bit)
B_BUS_IN  out  1  serial read-data bit to master
B_READY  out  1  B_BUS_IN valid this cycle
B_ACK  out  1  one-cycle transaction-complete pulse
B_SBSY  out  1  slave busy / split request

Behaviour:
- Reset: state IDLE, counters 0, shift registers 0. B_BUS_IN, B_READY, B_ACK and B_SBSY are all 0. Memory contents are not reset (X until written).
- Active = SEL && B_UTIL. All serial bits are LSB first, one bit per cycle.
- IDLE: when Active && A_ADD, capture bit 0 into the address shift register, set cnt=1 and go to ADDR.
  - If ADDR_W==1, apply the ADDR completion rule below on the same cycle.
- ADDR: each Active && A_ADD cycle shifts one bit and increments cnt.
  - On the cycle the ADDR_W-th bit is captured, sample B_RW.
    - B_RW=1 -> WDATA, cnt=0.
    - B_RW=0 and READ_LATENCY>0 -> BUSY; B_SBSY=1 from the next cycle.
    - B_RW=0 and READ_LATENCY==0 -> RDATA; memory read is combinational, so the first bit is driven the next cycle.
  - Active && !A_ADD inside ADDR: hold (no shift).
- WDATA: each Active cycle shifts one B_BUS_OUT bit.
  - After the DATA_W-th bit: write mem[addr] <= data on the same edge, go to ACK.
- BUSY: B_SBSY=1 for exactly READ_LATENCY cycles, counted with cnt.
  - Read data is latched into the output shift register on entry.
  - At the end of the count, drop B_SBSY and go to RWAIT. SEL/B_UTIL are ignored while in BUSY.
- RWAIT: wait for Active (re-grant after split resume); no address is re-sent. Then go to RDATA.
- RDATA: each Active cycle drives B_READY=1 and B_BUS_IN=data[cnt].
  - After DATA_W bits, go to ACK.
  - !Active inside RDATA pauses the transfer: B_READY=0, B_BUS_IN=0, cnt holds.
- ACK: B_ACK=1 for exactly one cycle, then IDLE.
- Abort: B_UTIL=0 or SEL=0 while in ADDR or WDATA for 2 consecutive cycles returns to IDLE. No memory write occurs; no ACK is issued.
- A_ADD=1 seen in WDATA/RDATA is ignored (protocol error, not recovered).
- B_BUS_IN is 0 whenever B_READY=0.
- Address wraps naturally within ADDR_W bits; no out-of-range case exists.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. A partial write is never committed.
- Throughput: write = ADDR_W+DATA_W+1 active cycles; read = ADDR_W+DATA_W+1(+READ_LATENCY+re-grant) cycles.

Decomposition:
- Shared package bus_pkg holds:
  - state enum slave_state_t {IDLE, ADDR, WDATA, BUSY, RWAIT, RDATA, ACK};
  - default widths ADDR_W_DEF=12 and DATA_W_DEF=8.
- One sub-module, slave_mem: a 2**ADDR_W x DATA_W register array with synchronous write (we, waddr, wdata) and combinational read (raddr -> rdata).
- The FSM, counters and shift registers stay in bus_slave_port.

Test Plan:
- Write 0xA5 to addr 0x123: hold SEL=B_UTIL=1, 12 A_ADD address bits, B_RW=1, then 8 data bits -> B_ACK pulses exactly 1 cycle after the last data bit; a subsequent read returns 0xA5.
- Read addr 0x123 with READ_LATENCY=0: send the address with B_RW=0 -> B_READY high for 8 consecutive cycles; B_BUS_IN sequence 1,0,1,0,0,1,0,1; B_ACK one cycle after.
- Split read with READ_LATENCY=5: address completes -> B_SBSY=1 for exactly 5 cycles, B_READY=0 throughout. Then B_UTIL=0 for 3 cycles, then Active -> data is streamed with no address resend; B_ACK follows.
- Abort: write addr 0x010, drop B_UTIL for 2 cycles after 4 data bits -> return to IDLE, no B_ACK; a read of 0x010 still returns the prior value.
- Pause in RDATA: deassert B_UTIL for 1 cycle mid-read -> B_READY=0 and B_BUS_IN=0 that cycle, the remaining bits resume in order, 8 B_READY cycles in total.
- Async reset: assert RSTN=0 mid-WDATA, off-clock-edge -> all outputs 0 immediately; after release the memory location is unchanged and a new transaction completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default widths for the serial shared-bus slave port.
// The state enum is also used by the debug output of the top.
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      BUSY,
      RWAIT,
      RDATA,
      ACK
   } slave_state_t;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bus_slave_port_if.sv
// One slave slot of the serial shared bus, seen from the master and slave sides.
// B_READY is a valid strobe with no back-pressure: B_BUS_IN is meaningful only
// on cycles where B_READY=1 and is held at 0 otherwise.
interface bus_slave_port_if;

   logic SEL;
   logic B_UTIL;
   logic A_ADD;
   logic B_BUS_OUT;
   logic B_RW;
   logic B_BUS_IN;
   logic B_READY;
   logic B_ACK;
   logic B_SBSY;

   modport master (
      output SEL, B_UTIL, A_ADD, B_BUS_OUT, B_RW,
      input  B_BUS_IN, B_READY, B_ACK, B_SBSY
   );

   modport slave (
      input  SEL, B_UTIL, A_ADD, B_BUS_OUT, B_RW,
      output B_BUS_IN, B_READY, B_ACK, B_SBSY
   );

endinterface

// File: rtl/bus_slave_port_mem.sv
// Local word memory of the slave port: synchronous write, combinational read.
// Contents are intentionally not reset.
module slave_mem #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_slave_port.sv
// Slave-side responder: deserialises address/write data, commits writes, serialises
// read data back with an optional split (busy) phase, and pulses ACK on completion.
module bus_slave_port
   import bus_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int READ_LATENCY = 0
) (
   input  logic             CLK,
   input  logic             RSTN,
   bus_slave_port_if.slave  bus,
   output slave_state_t     o_dbg_state
);

   localparam int CNT_W  = $clog2(max3(ADDR_W, DATA_W, READ_LATENCY) + 1);
   localparam int LAT_M1 = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(LAT_M1);

   slave_state_t      r_state, w_next, w_addr_target;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr, w_addr_shift;
   logic [DATA_W-1:0] r_wdata, w_wdata_shift, r_rdata, w_mem_rdata;
   logic              r_inact;
   logic              w_active, w_addr_strobe, w_addr_last, w_data_last, w_lat_last;
   logic              w_abort, w_we, w_ready;

   assign w_active      = bus.SEL && bus.B_UTIL;
   assign w_addr_strobe = w_active && bus.A_ADD;
   // LSB-first: new bit enters at the MSB, so after N shifts bit 0 sits at position 0.
   assign w_addr_shift  = ADDR_W'({bus.B_BUS_OUT, r_addr} >> 1);
   assign w_wdata_shift = DATA_W'({bus.B_BUS_OUT, r_wdata} >> 1);
   assign w_addr_last   = (r_state == IDLE) ? (ADDR_W == 1) : (r_cnt == ADDR_LAST);
   assign w_data_last   = (r_cnt == DATA_LAST);
   assign w_lat_last    = (r_cnt == LAT_LAST);
   assign w_abort       = !w_active && r_inact;
   assign w_addr_target = bus.B_RW ? WDATA : ((READ_LATENCY > 0) ? BUSY : RDATA);
   assign o_dbg_state   = r_state;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_addr_strobe) w_next = w_addr_last ? w_addr_target : ADDR;
         ADDR:    if (w_abort) w_next = IDLE;
                  else if (w_addr_strobe && w_addr_last) w_next = w_addr_target;
         WDATA:   if (w_abort) w_next = IDLE;
                  else if (w_active && w_data_last) w_next = ACK;
         BUSY:    if (w_lat_last) w_next = RWAIT;
         RWAIT:   if (w_active) w_next = RDATA;
         RDATA:   if (w_active && w_data_last) w_next = ACK;
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_ready      = (r_state == RDATA) && w_active;
      w_we         = (r_state == WDATA) && w_active && w_data_last;
      bus.B_READY  = w_ready;
      bus.B_BUS_IN = w_ready && r_rdata[0];
      bus.B_ACK    = (r_state == ACK);
      bus.B_SBSY   = (r_state == BUSY);
   end

   // Read data is captured on the address-completion edge, using the address
   // including the bit arriving that cycle, so no extra lookup cycle is needed.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_inact <= 1'b0;
      end else begin
         r_inact <= ((r_state == ADDR) || (r_state == WDATA)) && !w_active;
         case (r_state)
            IDLE, ADDR: begin
               if (w_addr_strobe) begin
                  r_addr <= w_addr_shift;
                  if (w_addr_last) begin
                     r_cnt   <= '0;
                     r_rdata <= w_mem_rdata;
                  end else begin
                     r_cnt <= (r_state == IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
                  end
               end
            end
            WDATA: begin
               if (w_active) begin
                  r_wdata <= w_wdata_shift;
                  r_cnt   <= w_data_last ? '0 : r_cnt + CNT_W'(1);
               end
            end
            BUSY: r_cnt <= w_lat_last ? '0 : r_cnt + CNT_W'(1);
            RDATA: begin
               if (w_active) begin
                  r_rdata <= r_rdata >> 1;
                  r_cnt   <= w_data_last ? '0 : r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   slave_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .i_clk   (CLK),
      .i_we    (w_we),
      .i_waddr (r_addr),
      .i_wdata (w_wdata_shift),
      .i_raddr (w_addr_shift),
      .o_rdata (w_mem_rdata)
   );

endmodule
